ahb_apb_bridge_param: RTL
=========================

# ahb_apb_bridge_param

Parametrised AHB-to-APB bridge. It converts single AHB transfers into APB3 transfers to one of NUM_SLV memory-mapped peripherals. It adds APB wait states (Pready), slave error propagation (Pslverr to a two-cycle AHB ERROR response), and address-decode errors and Pready timeouts, none of which the fixed three-slave bridge has. It sits between the AHB interconnect and the APB peripheral bus, and is the DUT behind the team's AHB/APB BFM interface.

## Interface
- ADDR_W, 32, address width on both buses
- DATA_W, 32, data width on both buses
- NUM_SLV, 3, number of APB slaves; width of Pselx (1..16)
- SLV_BASE, 32'h8000_0000, base address of slave 0
- SLV_SIZE_LOG2, 24, log2 of each slave's window; slave i spans SLV_BASE + i·2^SLV_SIZE_LOG2
- TIMEOUT, 16, maximum ACCESS cycles before forced termination (≥2)

Ports:
- clk  in  1  clock; all logic on the rising edge
- resetn  in  1  asynchronous, active-low reset
- Hwrite  in  1  1 = write
- Hreadyin  in  1  AHB bus ready
- Htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- Haddr  in  ADDR_W  AHB address
- Hwdata  in  DATA_W  AHB write data (data phase)
- Hrdata  out  DATA_W  AHB read data
- Hresp  out  2  00 OKAY, 01 ERROR
- Hreadyout  out  1  bridge ready
- Pselx  out  NUM_SLV  one-hot APB select
- Penable  out  1  APB enable
- Pwrite  out  1  APB direction
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Prdata  in  DATA_W  APB read data
- Pready  in  1  APB slave ready
- Pslverr  in  1  APB slave error

## Operation
- All outputs are registered.
- Reset values: Hreadyout=1, Hresp=00, Hrdata=0, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, state IDLE, timeout counter 0.
- FSM states: IDLE, DATA, SETUP, ACCESS, ERR1, ERR2.
- IDLE: accept a transfer when Hreadyin=1 and Htrans[1]=1. Latch Haddr and Hwrite, compute the slave index, go to DATA, and set Hreadyout=0. Htrans IDLE or BUSY is ignored and leaves the bridge in IDLE.
- Decode: off = Haddr − SLV_BASE; idx = off >> SLV_SIZE_LOG2. The address is valid only if Haddr ≥ SLV_BASE and idx < NUM_SLV. Use full ADDR_W arithmetic; no wrap-around (an address below the base is invalid, never a large positive offset).
- DATA: if the write flag is set, capture Hwdata into Pwdata; on a read, Pwdata holds. Valid address: go to SETUP with Pselx[idx]=1, Paddr = latched address, Pwrite = latched Hwrite. Invalid address: go to ERR1 with no APB activity.
- SETUP: go to ACCESS and set Penable=1; clear the counter.
- ACCESS: the counter increments each cycle Pready=0.
  - Pready=1, Pslverr=0: go to IDLE. Clear Pselx and Penable, set Hreadyout=1 and Hresp=00. On a read, load Hrdata with Prdata.
  - Pready=1, Pslverr=1: go to ERR1 and clear Pselx and Penable. Hrdata is not updated.
  - Pready=0 with counter = TIMEOUT−1: go to ERR1 and clear Pselx and Penable.
- ERR1: Hresp=01, Hreadyout=0. Go to ERR2.
- ERR2: Hresp=01, Hreadyout=1. Go to IDLE; Hresp returns to 00 in IDLE.
- Paddr, Pwrite and Pwdata hold their values from SETUP until the next SETUP. Hrdata holds until the next successful read.
- Reset asserted mid-transfer: all outputs take their reset values immediately (asynchronously). The AHB transfer is abandoned and no response is given.
- Pready and Pslverr are ignored outside ACCESS.

## Timing
- Zero-wait transfer, with the address sampled at edge E1:
  - DATA during E1–E2
  - SETUP during E2–E3
  - ACCESS during E3–E4
  - Hreadyout=1 from E4
  - Hreadyout is low for 3 cycles. Each Pready wait state adds 1 cycle.
- The next address phase is presented while Hreadyout=1 after E4 and is sampled at E5. Back-to-back throughput is one transfer per 4 cycles.
- Slave error: Hreadyout low for 4 cycles, with Hresp=01 for 2 cycles (ERR1, ERR2).
- Decode error: DATA → ERR1 → ERR2, so Hreadyout is low for 2 cycles and Pselx never asserts.
- Timeout: ACCESS lasts exactly TIMEOUT cycles before ERR1.

## Test plan
- Write 0x8100_0010 ← 0xDEAD_BEEF, Pready=1: Pselx=3'b010 for 2 cycles, Paddr=0x8100_0010, Pwdata=0xDEAD_BEEF, Penable high 1 cycle, Hreadyout low 3 cycles, Hresp=00.
- Read 0x8200_0004, Prdata=0x1234_5678, Pready low for 2 cycles: Pselx=3'b100, ACCESS lasts 3 cycles, Hrdata=0x1234_5678 when Hreadyout rises (low 5 cycles total).
- Write 0x8000_0000 with Pslverr=1 at Pready: Pselx=001 drops after ACCESS, then Hresp=01 with Hreadyout=0, then Hresp=01 with Hreadyout=1, then Hresp=00.
- Read 0x8300_0000 and 0x7FFF_FFFC: Pselx stays 0, two-cycle ERROR response each time, Hrdata unchanged.
- Pready held 0 with TIMEOUT=16: ACCESS lasts 16 cycles, then a two-cycle ERROR, then IDLE. A following write 0x8000_0008 completes OKAY.
- resetn low during ACCESS: Pselx=0, Penable=0, Hreadyout=1 without waiting for a clock edge. After release, Htrans=01 (BUSY) is ignored and a following NONSEQ proceeds normally.

Source files
------------

// File: rtl/ahb_apb_bridge_param.sv
// ahb_apb_bridge_param: single-transfer AHB to APB3 bridge with address decode,
// Pready wait states, slave-error and timeout reporting as a two-cycle AHB ERROR.
module ahb_apb_bridge_param #(
    parameter int                ADDR_W        = 32,
    parameter int                DATA_W        = 32,
    parameter int                NUM_SLV       = 3,
    parameter logic [ADDR_W-1:0] SLV_BASE      = 32'h8000_0000,
    parameter int                SLV_SIZE_LOG2 = 24,
    parameter int                TIMEOUT       = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               Hwrite,
    input  logic               Hreadyin,
    input  logic [1:0]         Htrans,
    input  logic [ADDR_W-1:0]  Haddr,
    input  logic [DATA_W-1:0]  Hwdata,
    output logic [DATA_W-1:0]  Hrdata,
    output logic [1:0]         Hresp,
    output logic               Hreadyout,
    output logic [NUM_SLV-1:0] Pselx,
    output logic               Penable,
    output logic               Pwrite,
    output logic [ADDR_W-1:0]  Paddr,
    output logic [DATA_W-1:0]  Pwdata,
    input  logic [DATA_W-1:0]  Prdata,
    input  logic               Pready,
    input  logic               Pslverr
);
    localparam int IDX_W = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_ERR1   = 3'd4;
    localparam logic [2:0] S_ERR2   = 3'd5;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic              r_valid;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_idx;
    logic              w_valid;
    logic              w_start;
    logic [NUM_SLV-1:0] w_sel;
    logic              w_unused;

    // An address below the base must not wrap into a large in-range offset.
    assign w_off    = Haddr - SLV_BASE;
    assign w_idx    = w_off >> SLV_SIZE_LOG2;
    assign w_valid  = (Haddr >= SLV_BASE) && (w_idx < ADDR_W'(NUM_SLV));
    assign w_start  = Hreadyin & Htrans[1];
    assign w_sel    = NUM_SLV'(1) << r_idx;
    assign w_unused = Htrans[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
            Hrdata    <= '0;
            Hresp     <= 2'b00;
            Hreadyout <= 1'b1;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_addr    <= Haddr;
                    r_write   <= Hwrite;
                    r_idx     <= w_idx[IDX_W-1:0];
                    r_valid   <= w_valid;
                    Hreadyout <= 1'b0;
                    r_state   <= S_DATA;
                end
                S_DATA: begin
                    if (r_write) Pwdata <= Hwdata;
                    if (r_valid) begin
                        Pselx   <= w_sel;
                        Paddr   <= r_addr;
                        Pwrite  <= r_write;
                        r_state <= S_SETUP;
                    end else begin
                        Hresp   <= 2'b01;
                        r_state <= S_ERR1;
                    end
                end
                S_SETUP: begin
                    Penable <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: if (Pready) begin
                    Pselx   <= '0;
                    Penable <= 1'b0;
                    if (Pslverr) begin
                        Hresp   <= 2'b01;
                        r_state <= S_ERR1;
                    end else begin
                        Hreadyout <= 1'b1;
                        Hresp     <= 2'b00;
                        if (!Pwrite) Hrdata <= Prdata;
                        r_state   <= S_IDLE;
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    Pselx   <= '0;
                    Penable <= 1'b0;
                    Hresp   <= 2'b01;
                    r_state <= S_ERR1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_ERR1: begin
                    Hreadyout <= 1'b1;
                    r_state   <= S_ERR2;
                end
                S_ERR2: begin
                    Hresp   <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
